inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Front-end fetch stage sitting directly upstream of the pipelined instruction cache. It generates sequential PCs, issues one-word read requests on the cache's upward-facing port, tracks the single in-flight request across cache misses, and buffers returned instructions in a circular queue for decode. Redirects from the back end flush the queue and squash any in-flight response.

## Interface
- DEPTH, 8: instruction queue entries; power of two, ≥2.
- RESET_PC, 32'h1ECEB000: first fetch address after reset.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- ufp_addr  out  32  cache request address (word aligned).
- ufp_rmask  out  4  4'hF when requesting, else 4'h0.
- ufp_wmask  out  4  constant 4'h0.
- ufp_wdata  out  32  constant 32'h0.
- ufp_rdata  in  32  instruction returned by cache.
- ufp_resp  in  1  cache response strobe.
- iq_valid  out  1  queue head holds an instruction.
- iq_pc  out  32  PC of head entry.
- iq_inst  out  32  instruction of head entry.
- iq_ready  in  1  decode consumes head when iq_valid & iq_ready.

## Operation
- State: fetch_pc, outstanding (1 request in flight), squash (in-flight response must be dropped), pending_pc (PC of in-flight request), queue (DEPTH × {pc, inst}, head/tail pointers, count 0..DEPTH).
- Request: ufp_rmask = 4'hF when (count + (outstanding & ~squash)) < DEPTH or redirect is high; ufp_addr = redirect ? redirect_pc : fetch_pc.
- Acceptance: request accepted in a cycle iff ufp_rmask ≠ 0 and (~outstanding or ufp_resp). The cache ignores requests presented while it is resolving a miss; the block re-presents the same address every cycle until accepted.
- On accept: outstanding←1, pending_pc←ufp_addr, fetch_pc←ufp_addr+4, squash←0.
- On ufp_resp with no accept: outstanding←0, squash←0.
- Response push: if ufp_resp & outstanding & ~squash & ~redirect, push {pending_pc, ufp_rdata} at tail. ufp_resp with outstanding=0 is a protocol error; ignored.
- Pop: iq_valid & iq_ready advances head. Push and pop in the same cycle keep count unchanged; push to a full queue cannot occur by the credit rule.
- Redirect (priority over push/pop): count←0, head←tail←0, iq_valid drops next cycle. If outstanding and no ufp_resp this cycle, squash←1 (response later discarded, then redirect target accepted that cycle). If ufp_resp this cycle, the returning word is dropped and redirect_pc accepted in the same cycle. If idle, redirect_pc accepted immediately.
- Redirect while squash already set: fetch_pc/ufp_addr updated to the newest redirect_pc; squash stays set.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits; PC arithmetic is 32-bit, wrap at 2^32 allowed.
- Only sequential prediction (PC+4); no branch prediction.

## Timing
- Reset: fetch_pc=RESET_PC, outstanding=0, squash=0, count=0, head=tail=0; outputs: iq_valid=0, iq_pc=0, iq_inst=0, ufp_rmask=4'hF (first cycle after reset presents RESET_PC), ufp_addr=RESET_PC, ufp_wmask=0, ufp_wdata=0.
- Cache hit: request accepted cycle t, ufp_resp at t+1, entry visible on iq_valid at t+2. Back-to-back hits sustain one instruction per cycle.
- Cache miss: response arrives ≥3 cycles after accept; address held stable on ufp_addr during the wait.
- iq_* outputs are registered queue contents (head entry), no combinational path from ufp_rdata.
- Reset mid-miss: all state cleared; a late cache response after reset is ignored since outstanding=0.

## Test plan
- Reset then always-hit cache (1-cycle latency) returning PC as data: iq delivers PCs 1ECEB000, 1ECEB004, … one per cycle from cycle 3; no gaps with iq_ready=1.
- Miss of 10 cycles on 1ECEB008: ufp_addr holds 1ECEB00C (presented, not accepted) throughout; exactly one entry per PC, order preserved.
- iq_ready=0 with DEPTH=8: exactly 8 entries queued, ufp_rmask drops to 0 with one pending credit accounted; releasing iq_ready resumes fetch without loss or duplication.
- Redirect to 0x00001000 during a miss on 1ECEB010: queue empties next cycle, late response for 1ECEB010 discarded, first delivered entry has pc=0x00001000.
- Redirect in same cycle as ufp_resp: returned word dropped, 0x00002000 accepted that cycle, delivered 2 cycles later.
- Simultaneous push and pop at count=DEPTH−1 and pointer wrap: count stays, data order intact across wrap.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Sequential instruction fetch front end. It generates PC+4
//               fetch addresses and issues one-word reads to the instruction
//               cache. It tracks a single in-flight request across misses and
//               buffers returned words in a circular queue for decode. A
//               redirect flushes the queue and squashes an in-flight response.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst             clock; synchronous active-high reset
//   redirect/_pc         flush and restart fetch at redirect_pc (word aligned)
//   ufp_addr/rmask       cache read request (rmask = 4'hF while requesting)
//   ufp_wmask/wdata      tied off, this port never writes
//   ufp_rdata/resp       cache read data and response strobe
//   iq_valid/pc/inst     registered head entry of the instruction queue
//   iq_ready             decode consumes the head when iq_valid & iq_ready
// ============================================================================
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ufp_addr,
  output logic [3:0]  ufp_rmask,
  output logic [3:0]  ufp_wmask,
  output logic [31:0] ufp_wdata,
  input  logic [31:0] ufp_rdata,
  input  logic        ufp_resp,
  output logic        iq_valid,
  output logic [31:0] iq_pc,
  output logic [31:0] iq_inst,
  input  logic        iq_ready
);

  localparam int unsigned     PTR_W     = $clog2(DEPTH);
  localparam int unsigned     CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Fetch / request tracking state
  logic [31:0]      fetch_pc;
  logic [31:0]      pending_pc;
  logic             outstanding;
  logic             squash;

  // Queue state
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic [31:0]      redirect_addr;
  logic [CNT_W-1:0] credits_used;
  logic             req;
  logic             accept;
  logic             push;
  logic             pop;
  logic             unused_redirect_lsbs;

  assign redirect_addr        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A live in-flight request already owns a queue slot; a squashed one does
  // not, since its data will be thrown away.
  assign credits_used = count + CNT_W'(outstanding & ~squash);
  assign req          = (credits_used < DEPTH_CNT) | redirect;

  // The cache only takes a new request when idle or when finishing the
  // previous one; otherwise the same address is re-presented.
  assign accept = req & (~outstanding | ufp_resp);
  assign push   = ufp_resp & outstanding & ~squash & ~redirect;
  assign pop    = iq_valid & iq_ready & ~redirect;

  assign ufp_addr  = redirect ? redirect_addr : fetch_pc;
  assign ufp_rmask = req ? 4'hF : 4'h0;
  assign ufp_wmask = 4'h0;
  assign ufp_wdata = 32'h0;

  // Head entry comes straight from queue storage; gated to zero when empty
  // so the outputs are clean after reset and flush.
  assign iq_valid = (count != '0);
  assign iq_pc    = iq_valid ? pc_mem[head]   : 32'h0;
  assign iq_inst  = iq_valid ? inst_mem[head] : 32'h0;

  // Request tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      pending_pc  <= 32'h0;
      outstanding <= 1'b0;
      squash      <= 1'b0;
    end else if (accept) begin
      outstanding <= 1'b1;
      pending_pc  <= ufp_addr;
      fetch_pc    <= ufp_addr + 32'd4;
      squash      <= 1'b0;
    end else begin
      if (ufp_resp) begin
        outstanding <= 1'b0;
        squash      <= 1'b0;
      end
      // A redirect that cannot be accepted means a request is still in
      // flight with no response this cycle: remember to drop its data and
      // keep presenting the newest target.
      if (redirect) begin
        fetch_pc <= redirect_addr;
        if (outstanding) begin
          squash <= 1'b1;
        end
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage (no reset needed; outputs are gated by iq_valid)
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= pending_pc;
      inst_mem[tail] <= ufp_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Self-checking bench for inst_fetch_queue. A cache model with
//               per-address latency answers requests; a scoreboard queue of
//               expected {pc, inst} entries is checked by a monitor whenever
//               decode consumes an entry. Directed phases cover reset, hits,
//               a miss, redirect during a miss, a full queue, push+pop at
//               DEPTH-1 and redirect coincident with a response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h1ECEB000;
  localparam logic [31:0] KEY      = 32'hC0DE0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ufp_addr;
  logic [3:0]  ufp_rmask;
  logic [3:0]  ufp_wmask;
  logic [31:0] ufp_wdata;
  logic [31:0] ufp_rdata;
  logic        ufp_resp;
  logic        iq_valid;
  logic [31:0] iq_pc;
  logic [31:0] iq_inst;
  logic        iq_ready;

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ufp_addr    (ufp_addr),
    .ufp_rmask   (ufp_rmask),
    .ufp_wmask   (ufp_wmask),
    .ufp_wdata   (ufp_wdata),
    .ufp_rdata   (ufp_rdata),
    .ufp_resp    (ufp_resp),
    .iq_valid    (iq_valid),
    .iq_pc       (iq_pc),
    .iq_inst     (iq_inst),
    .iq_ready    (iq_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_deliv  = 0;
  int          n_acc    = 0;
  bit          c_busy   = 1'b0;
  logic [31:0] c_pend   = 32'h0;
  int          c_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4 * i);
      e.inst = e.pc ^ KEY;
      exp_q.push_back(e);
    end
  endtask

  function automatic int lat(input logic [31:0] a);
    if (a == 32'h1ECEB008) return 10;
    if (a == 32'h1ECEB010) return 8;
    return 1;
  endfunction

  // Cache model: response driven at the falling edge, request sampled 1 ns
  // later once the front end's combinational request has settled.
  initial begin : cache_model
    bit was_busy;
    bit resp_now;
    ufp_resp  = 1'b0;
    ufp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && c_busy && c_cnt == 0) begin
        ufp_resp  = 1'b1;
        ufp_rdata = c_pend ^ KEY;
      end else begin
        ufp_resp  = 1'b0;
        ufp_rdata = 32'h0;
      end
      #1;
      if (rst) begin
        c_busy = 1'b0;
      end else begin
        was_busy = c_busy;
        resp_now = ufp_resp;
        if (resp_now) c_busy = 1'b0;
        if (ufp_rmask != 4'h0 && (!was_busy || resp_now)) begin
          c_busy = 1'b1;
          c_pend = ufp_addr;
          c_cnt  = lat(ufp_addr) - 1;
          n_acc++;
        end else if (c_busy) begin
          c_cnt--;
        end
      end
    end
  end

  // Monitor: every consumed entry must match the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && iq_valid && iq_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got pc %h, expected no entry", iq_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", iq_pc, e.pc);
          chk("sb_inst", iq_inst, e.inst);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n0;
    int d_e;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    iq_ready    = 1'b1;
    push_run(RESET_PC, 64);

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_iq_valid", 32'(iq_valid), 32'h0);
    chk("rst_iq_pc", iq_pc, 32'h0);
    chk("rst_iq_inst", iq_inst, 32'h0);
    chk("rst_rmask", 32'(ufp_rmask), 32'hF);
    chk("rst_addr", ufp_addr, RESET_PC);
    chk("rst_wmask", 32'(ufp_wmask), 32'h0);
    chk("rst_wdata", ufp_wdata, 32'h0);

    // c0..c3: hit pipeline start-up
    @(negedge clk); rst = 1'b0; #3;
    chk("c0_addr", ufp_addr, RESET_PC);
    chk("c0_rmask", 32'(ufp_rmask), 32'hF);
    chk("c0_valid", 32'(iq_valid), 32'h0);
    @(negedge clk); #3;
    chk("c1_addr", ufp_addr, 32'h1ECEB004);
    chk("c1_valid", 32'(iq_valid), 32'h0);
    @(negedge clk); #3;
    chk("c2_valid", 32'(iq_valid), 32'h1);
    chk("c2_pc", iq_pc, RESET_PC);
    chk("c2_addr", ufp_addr, 32'h1ECEB008);
    @(negedge clk); #3;
    chk("c3_valid", 32'(iq_valid), 32'h1);
    chk("c3_pc", iq_pc, 32'h1ECEB004);

    // c3..c11: miss on 1ECEB008, next address held
    for (int k = 3; k <= 11; k++) begin
      if (k != 3) begin
        @(negedge clk); #3;
      end
      chk("miss_hold_addr", ufp_addr, 32'h1ECEB00C);
      chk("miss_hold_rmask", 32'(ufp_rmask), 32'hF);
    end

    // c12: miss resolves, 1ECEB00C accepted; hold decode to keep entries
    @(negedge clk); iq_ready = 1'b0; #3;
    chk("c12_addr", ufp_addr, 32'h1ECEB00C);
    @(negedge clk); #3;
    chk("c13_addr", ufp_addr, 32'h1ECEB010);
    chk("c13_valid", 32'(iq_valid), 32'h1);
    repeat (3) @(negedge clk);

    // c17: redirect during miss on 1ECEB010
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h00001000; #3;
    chk("rd1_addr", ufp_addr, 32'h00001000);
    chk("rd1_valid_before", 32'(iq_valid), 32'h1);
    @(negedge clk);
    redirect = 1'b0;
    iq_ready = 1'b1;
    exp_q.delete();
    push_run(32'h00001000, 64);
    #3;
    chk("rd1_flushed", 32'(iq_valid), 32'h0);
    chk("rd1_hold_addr", ufp_addr, 32'h00001000);
    for (int k = 19; k <= 21; k++) begin
      @(negedge clk); #3;
      chk("rd1_wait_addr", ufp_addr, 32'h00001000);
    end
    @(negedge clk); #3;
    chk("c22_valid", 32'(iq_valid), 32'h0);
    @(negedge clk); #3;
    chk("c23_valid", 32'(iq_valid), 32'h1);
    chk("c23_pc", iq_pc, 32'h00001000);

    // c28: stall decode until the queue is full
    repeat (4) @(negedge clk);
    @(negedge clk); iq_ready = 1'b0; n0 = n_acc;
    repeat (14) @(negedge clk);
    #3;
    chk("full_accepts", 32'(n_acc - n0), 32'd6);
    chk("full_rmask", 32'(ufp_rmask), 32'h0);
    chk("full_no_outstanding", 32'(c_busy), 32'h0);
    chk("full_valid", 32'(iq_valid), 32'h1);
    if (exp_q.size() > 0) chk("full_head_pc", iq_pc, exp_q[0].pc);
    @(negedge clk); iq_ready = 1'b1;

    // Push and pop together at count DEPTH-1
    repeat (11) @(negedge clk);
    @(negedge clk); iq_ready = 1'b0; #3;
    chk("d0_rmask", 32'(ufp_rmask), 32'hF);
    @(negedge clk); iq_ready = 1'b1; #3;
    chk("d1_rmask_credit", 32'(ufp_rmask), 32'h0);
    @(negedge clk); #3;
    chk("d2_rmask", 32'(ufp_rmask), 32'hF);
    chk("d2_valid", 32'(iq_valid), 32'h1);

    // Redirect coincident with a cache response; low bits ignored
    repeat (9) @(negedge clk);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h00002003; #3;
    chk("rd2_addr", ufp_addr, 32'h00002000);
    chk("rd2_rmask", 32'(ufp_rmask), 32'hF);
    @(negedge clk);
    redirect = 1'b0;
    exp_q.delete();
    push_run(32'h00002000, 64);
    #3;
    chk("rd2_flushed", 32'(iq_valid), 32'h0);
    @(negedge clk); #3;
    chk("rd2_valid", 32'(iq_valid), 32'h1);
    chk("rd2_pc", iq_pc, 32'h00002000);
    chk("rd2_inst", iq_inst, 32'h00002000 ^ KEY);
    d_e = n_deliv;
    repeat (10) @(negedge clk);
    #3;
    chk("rd2_stream_rate", 32'(n_deliv - d_e), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
